// File: rtl/floor_switch.sv
// Player floor/position owner and stair-transition sequencer for the tower game.
// A stair hit runs fade-out, floor change, placement at the arrival stair, then fade-in.
module floor_switch #(
  parameter int STEP_CYCLES = 1562500,
  parameter int TOP_FLOOR   = 4,
  parameter int START_X     = 6,
  parameter int START_Y     = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_x,
  input  logic [3:0]  req_y,
  input  logic [3:0]  up_x,
  input  logic [3:0]  up_y,
  input  logic [3:0]  down_x,
  input  logic [3:0]  down_y,
  output logic [15:0] floor,
  output logic [3:0]  player_x,
  output logic [3:0]  player_y,
  output logic [3:0]  fade,
  output logic        busy,
  output logic        done
);

  localparam int              CW       = $clog2(STEP_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [15:0]     TOP_F    = 16'(TOP_FLOOR);
  localparam logic [3:0]      FADE_MAX = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FADE_OUT,
    S_SWAP,
    S_SETTLE,
    S_FADE_IN
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     fade_q, fade_d;
  logic [15:0]    floor_q, floor_d;
  logic [3:0]     px_q, px_d;
  logic [3:0]     py_q, py_d;
  logic           dir_up_q, dir_up_d;
  logic           done_q, done_d;

  logic           cnt_last;
  logic           up_hit;
  logic           down_hit;

  assign cnt_last = (cnt_q == CNT_LAST);
  // Dummy (0,0) stairs on the end floors are neutralised by the floor guards.
  assign up_hit   = (req_x == up_x) && (req_y == up_y) && (floor_q < TOP_F);
  assign down_hit = (req_x == down_x) && (req_y == down_y) && (floor_q != 16'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fade_d   = fade_q;
    floor_d  = floor_q;
    px_d     = px_q;
    py_d     = py_q;
    dir_up_d = dir_up_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          px_d  = req_x;
          py_d  = req_y;
          cnt_d = '0;
          if (up_hit) begin
            dir_up_d = 1'b1;
            state_d  = S_FADE_OUT;
          end else if (down_hit) begin
            dir_up_d = 1'b0;
            state_d  = S_FADE_OUT;
          end
        end
      end

      S_FADE_OUT: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (fade_q == FADE_MAX) begin
            state_d = S_SWAP;
          end else begin
            fade_d = fade_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SWAP: begin
        floor_d = dir_up_q ? (floor_q + 16'd1) : (floor_q - 16'd1);
        state_d = S_SETTLE;
      end

      S_SETTLE: begin
        // Stair inputs now describe the new floor; arrive on the opposite stair.
        px_d    = dir_up_q ? down_x : up_x;
        py_d    = dir_up_q ? down_y : up_y;
        cnt_d   = '0;
        state_d = S_FADE_IN;
      end

      S_FADE_IN: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (fade_q == 4'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            fade_d = fade_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fade_q   <= 4'd0;
      floor_q  <= 16'd0;
      px_q     <= 4'(START_X);
      py_q     <= 4'(START_Y);
      dir_up_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fade_q   <= fade_d;
      floor_q  <= floor_d;
      px_q     <= px_d;
      py_q     <= py_d;
      dir_up_q <= dir_up_d;
      done_q   <= done_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign floor     = floor_q;
  assign player_x  = px_q;
  assign player_y  = py_q;
  assign fade      = fade_q;
  assign done      = done_q;

endmodule
